// File: rtl/global_mem_responder_if.sv
// Request/response bus between the global-memory cache port and the responder.
// Handshake: the initiator raises mem_enable with mem_write_enable, mem_addr,
// mem_write_data and mem_write_bytes stable and holds it until it sees a
// one-cycle mem_finished_action pulse. It must then drop mem_enable for at
// least one cycle before the next request. mem_read_data is valid in the pulse
// cycle and holds until the next read completes.
interface global_mem_responder_if;
  logic         mem_enable;
  logic         mem_write_enable;
  logic [25:0]  mem_addr;
  logic [127:0] mem_write_data;
  logic [7:0]   mem_write_bytes;
  logic [127:0] mem_read_data;
  logic         mem_finished_action;

  modport master (
    output mem_enable, mem_write_enable, mem_addr, mem_write_data, mem_write_bytes,
    input  mem_read_data, mem_finished_action
  );

  modport slave (
    input  mem_enable, mem_write_enable, mem_addr, mem_write_data, mem_write_bytes,
    output mem_read_data, mem_finished_action
  );
endinterface

// File: rtl/global_mem_responder.sv
// Target-side global-memory model: serves one 128-bit line request at a time
// from a DEPTH-line store, pulses mem_finished_action on completion, and keeps
// saturating read/write counters plus a sticky out-of-range flag.
module global_mem_responder #(
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  global_mem_responder_if.slave        bus,
  output logic                         busy,
  output logic                         addr_error,
  output logic [15:0]                  read_count,
  output logic [15:0]                  write_count,
  output logic [2:0]                   fsm_state
);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int LAT_W = $clog2(READ_LATENCY + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ACCESS    = 3'd1,
    READ_WAIT = 3'd2,
    RESPOND   = 3'd3,
    RELEASE   = 3'd4
  } state_t;

  state_t state, state_next;

  logic [127:0] store [DEPTH];

  // Request fields captured in IDLE; the live bus is ignored while busy.
  logic             req_we;
  logic [25:0]      req_addr;
  logic [127:0]     req_data;
  logic [7:0]       req_mask;

  logic [LAT_W-1:0] lat_cnt;
  logic [127:0]     rd_pipe;
  logic [127:0]     read_data_q;
  logic             addr_error_q;
  logic [15:0]      read_count_q;
  logic [15:0]      write_count_q;

  logic             req_oor;
  logic [IDX_W-1:0] req_idx;
  logic [127:0]     rd_word;
  logic [127:0]     capture_src;
  logic             do_write;
  logic             do_issue;
  logic             do_capture;

  // Address decode and array read word; out-of-range reads yield zero.
  always_comb begin
    req_oor     = ({6'd0, req_addr} >= 32'(DEPTH));
    req_idx     = req_addr[IDX_W-1:0];
    rd_word     = req_oor ? 128'd0 : store[req_idx];
    capture_src = (READ_LATENCY == 1) ? rd_word : rd_pipe;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and per-state strobes.
  always_comb begin
    state_next = state;
    do_write   = 1'b0;
    do_issue   = 1'b0;
    do_capture = 1'b0;
    case (state)
      IDLE: begin
        if (bus.mem_enable) state_next = ACCESS;
      end
      ACCESS: begin
        if (req_we) begin
          do_write   = !req_oor;
          state_next = RESPOND;
        end else begin
          do_issue = 1'b1;
          if (READ_LATENCY == 1) begin
            do_capture = 1'b1;
            state_next = RESPOND;
          end else begin
            state_next = READ_WAIT;
          end
        end
      end
      READ_WAIT: begin
        if (lat_cnt == LAT_W'(1)) begin
          do_capture = 1'b1;
          state_next = RESPOND;
        end
      end
      RESPOND: state_next = RELEASE;
      RELEASE: begin
        if (!bus.mem_enable) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Latch the request fields when a new request is accepted.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_we   <= 1'b0;
      req_addr <= '0;
      req_data <= '0;
      req_mask <= '0;
    end else if (state == IDLE && bus.mem_enable) begin
      req_we   <= bus.mem_write_enable;
      req_addr <= bus.mem_addr;
      req_data <= bus.mem_write_data;
      req_mask <= bus.mem_write_bytes;
    end
  end

  // Line store: halfword-lane masked write; contents survive reset.
  always_ff @(posedge clk) begin
    if (do_write && !reset) begin
      for (int i = 0; i < 8; i++) begin
        if (req_mask[i]) store[req_idx][16*i +: 16] <= req_data[16*i +: 16];
      end
    end
  end

  // First read stage, modelling a registered BRAM output.
  always_ff @(posedge clk) begin
    if (do_issue) rd_pipe <= rd_word;
  end

  // Latency counter: loaded on issue, counts down through READ_WAIT.
  always_ff @(posedge clk) begin
    if (reset)                   lat_cnt <= '0;
    else if (do_issue)           lat_cnt <= LAT_W'(READ_LATENCY - 1);
    else if (state == READ_WAIT) lat_cnt <= lat_cnt - LAT_W'(1);
  end

  // Read data register, updated only when a read completes.
  always_ff @(posedge clk) begin
    if (reset)           read_data_q <= '0;
    else if (do_capture) read_data_q <= capture_src;
  end

  // Sticky out-of-range flag, set when the request is in ACCESS.
  always_ff @(posedge clk) begin
    if (reset)                          addr_error_q <= 1'b0;
    else if (state == ACCESS && req_oor) addr_error_q <= 1'b1;
  end

  // Saturating completion counters, bumped in the RESPOND cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      read_count_q  <= '0;
      write_count_q <= '0;
    end else if (state == RESPOND) begin
      if (req_we) begin
        if (write_count_q != 16'hFFFF) write_count_q <= write_count_q + 16'd1;
      end else begin
        if (read_count_q != 16'hFFFF) read_count_q <= read_count_q + 16'd1;
      end
    end
  end

  assign bus.mem_read_data       = read_data_q;
  assign bus.mem_finished_action = (state == RESPOND);
  assign busy                    = (state != IDLE);
  assign addr_error              = addr_error_q;
  assign read_count              = read_count_q;
  assign write_count             = write_count_q;
  assign fsm_state               = state;
endmodule

// File: tb/tb_global_mem_responder.sv
// Bench for global_mem_responder: directed cases plus random traffic against a
// line-array reference model; a monitor pops expected read data and pulse
// cycle from queues whenever the finished pulse appears.
module tb_global_mem_responder;
  localparam int DEPTH = 1024;
  localparam int RL    = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        busy;
  logic        addr_error;
  logic [15:0] read_count;
  logic [15:0] write_count;
  logic [2:0]  fsm_state;
  int          cyc = 0;

  int checks = 0;
  int fails  = 0;

  // Scoreboard queues: expected mem_read_data and expected pulse cycle.
  logic [127:0] exp_q[$];
  int           cyc_q[$];

  // Reference model state.
  logic [127:0] ref_mem [DEPTH];
  logic [127:0] m_rd;
  int           m_rc;
  int           m_wc;
  logic         m_err;

  global_mem_responder_if bus ();

  global_mem_responder #(.DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .addr_error  (addr_error),
    .read_count  (read_count),
    .write_count (write_count),
    .fsm_state   (fsm_state)
  );

  // Clock and cycle counter.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Monitor: every finished pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && bus.mem_finished_action) begin
      if (exp_q.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_pulse: got pulse at cycle %0d expected none", cyc);
      end else begin
        logic [127:0] e;
        int c;
        e = exp_q.pop_front();
        c = cyc_q.pop_front();
        check("read_data", bus.mem_read_data, e);
        check("pulse_cycle", 128'(cyc), 128'(c));
      end
    end
  end

  // Driver: issue one request, wait for the pulse, hold enable, release.
  task automatic do_req(input logic we, input logic [25:0] addr, input logic [127:0] data,
                        input logic [7:0] mask, input int hold);
    logic         oor;
    logic [9:0]   idx;
    logic [127:0] exp;
    int           lat;
    int           waited;
    bit           got;
    oor = (addr >= 26'(DEPTH));
    idx = addr[9:0];
    if (we) begin
      if (!oor)
        for (int i = 0; i < 8; i++)
          if (mask[i]) ref_mem[idx][16*i +: 16] = data[16*i +: 16];
      exp = m_rd;
      if (m_wc < 65535) m_wc++;
      lat = 2;
    end else begin
      exp  = oor ? 128'd0 : ref_mem[idx];
      m_rd = exp;
      if (m_rc < 65535) m_rc++;
      lat = 1 + RL;
    end
    if (oor) m_err = 1'b1;

    @(negedge clk);
    bus.mem_enable       = 1'b1;
    bus.mem_write_enable = we;
    bus.mem_addr         = addr;
    bus.mem_write_data   = data;
    bus.mem_write_bytes  = mask;
    exp_q.push_back(exp);
    cyc_q.push_back(cyc + lat);

    waited = 0;
    got    = 1'b0;
    while (!got && waited < 20) begin
      @(negedge clk);
      waited++;
      // Bus contents other than enable are don't-care once accepted.
      bus.mem_write_enable = 1'($urandom);
      bus.mem_addr         = 26'($urandom);
      bus.mem_write_data   = rand128();
      bus.mem_write_bytes  = 8'($urandom);
      check("busy_active", 128'(busy), 128'd1);
      if (bus.mem_finished_action) got = 1'b1;
    end
    if (!got) begin
      checks++;
      fails++;
      $display("FAIL pulse_timeout: got no pulse after %0d cycles expected one", waited);
      exp_q.delete();
      cyc_q.delete();
    end

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("busy_hold", 128'(busy), 128'd1);
    end
    bus.mem_enable = 1'b0;
    @(negedge clk);
    if (hold == 0) @(negedge clk);
    check("busy_idle", 128'(busy), 128'd0);
    check("read_count", 128'(read_count), 128'(m_rc));
    check("write_count", 128'(write_count), 128'(m_wc));
    check("addr_error", 128'(addr_error), 128'(m_err));
    check("read_data_held", bus.mem_read_data, m_rd);
  endtask

  // Main stimulus sequence.
  initial begin
    logic [127:0] line_a;
    logic [127:0] line_b;
    int           t0;

    bus.mem_enable       = 1'b0;
    bus.mem_write_enable = 1'b0;
    bus.mem_addr         = '0;
    bus.mem_write_data   = '0;
    bus.mem_write_bytes  = '0;
    m_rd  = '0;
    m_rc  = 0;
    m_wc  = 0;
    m_err = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_read_data", bus.mem_read_data, 128'd0);
    check("rst_finished", 128'(bus.mem_finished_action), 128'd0);
    check("rst_busy", 128'(busy), 128'd0);
    check("rst_addr_error", 128'(addr_error), 128'd0);
    check("rst_read_count", 128'(read_count), 128'd0);
    check("rst_write_count", 128'(write_count), 128'd0);
    reset = 1'b0;

    // Full write then read back.
    line_a = 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF;
    do_req(1'b1, 26'd5, line_a, 8'hFF, 1);
    do_req(1'b0, 26'd5, 128'd0, 8'h00, 0);
    check("rw_line5", bus.mem_read_data, line_a);
    check("rw_wcount", 128'(write_count), 128'd1);
    check("rw_rcount", 128'(read_count), 128'd1);

    // Partial write clears lanes 0 and 2 only.
    do_req(1'b1, 26'd9, {128{1'b1}}, 8'hFF, 0);
    do_req(1'b1, 26'd9, 128'd0, 8'b0000_0101, 2);
    do_req(1'b0, 26'd9, 128'd0, 8'h00, 1);
    check("partial_line9", bus.mem_read_data, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_0000_FFFF_0000);

    // Empty mask still completes and changes nothing.
    do_req(1'b1, 26'd9, rand128(), 8'h00, 0);
    do_req(1'b0, 26'd9, 128'd0, 8'h00, 0);

    // Enable held well past the pulse: exactly one completion.
    do_req(1'b0, 26'd5, 128'd0, 8'h00, 6);

    // Out-of-range read, then aliasing out-of-range write leaves line 5 alone.
    do_req(1'b0, 26'h400, 128'd0, 8'h00, 0);
    check("oor_flag", 128'(addr_error), 128'd1);
    check("oor_zero", bus.mem_read_data, 128'd0);
    do_req(1'b1, 26'h405, rand128(), 8'hFF, 1);
    do_req(1'b0, 26'd5, 128'd0, 8'h00, 0);
    check("oor_store_intact", bus.mem_read_data, line_a);
    check("oor_sticky", 128'(addr_error), 128'd1);

    // Reset while a read sits in its latency wait.
    @(negedge clk);
    bus.mem_enable       = 1'b1;
    bus.mem_write_enable = 1'b0;
    bus.mem_addr         = 26'd9;
    t0 = cyc;
    @(negedge clk);
    @(negedge clk);
    check("mid_busy", 128'(busy), 128'd1);
    reset          = 1'b1;
    bus.mem_enable = 1'b0;
    @(negedge clk);
    check("mid_no_pulse", 128'(bus.mem_finished_action), 128'd0);
    check("mid_busy_clr", 128'(busy), 128'd0);
    check("mid_data_clr", bus.mem_read_data, 128'd0);
    check("mid_err_clr", 128'(addr_error), 128'd0);
    check("mid_rc_clr", 128'(read_count), 128'd0);
    check("mid_wc_clr", 128'(write_count), 128'd0);
    check("mid_elapsed", 128'(cyc - t0), 128'd3);
    reset = 1'b0;
    m_rd  = '0;
    m_rc  = 0;
    m_wc  = 0;
    m_err = 1'b0;
    do_req(1'b0, 26'd5, 128'd0, 8'h00, 0);
    check("after_reset_line5", bus.mem_read_data, line_a);

    // Fill lines 0..15, then random traffic.
    for (int a = 0; a < 16; a++) do_req(1'b1, 26'(a), rand128(), 8'hFF, 0);
    for (int n = 0; n < 150; n++) begin
      logic [25:0] addr;
      if ($urandom_range(0, 9) == 0) addr = 26'($urandom_range(DEPTH, 26'h3FF_FFFF));
      else                           addr = 26'($urandom_range(0, 15));
      line_b = rand128();
      do_req(1'($urandom_range(0, 1)), addr, line_b, 8'($urandom), $urandom_range(0, 3));
    end

    // Write counter saturation.
    @(negedge clk);
    force dut.write_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.write_count_q;
    m_wc = 65535;
    @(negedge clk);
    do_req(1'b1, 26'd3, rand128(), 8'hFF, 0);
    check("sat_wcount", 128'(write_count), 128'hFFFF);
    do_req(1'b0, 26'd3, 128'd0, 8'h00, 0);

    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      fails++;
      $display("FAIL pending_responses: got %0d outstanding expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  // Watchdog so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion by time limit expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
